writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile.sv | 97 +++++++++
 tb/tb_writeback_regfile.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback-stage result mux, register file with same-cycle write-through
// bypass to the decode read ports, live x10 view and committed-write counter.
module writeback_regfile #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned ADDRESS_WIDTH       = 32,
    parameter int unsigned REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           regwritew,
    input  logic [2:0]                     resultsrcw,
    input  logic [DATA_WIDTH-1:0]          aluresultw,
    input  logic [DATA_WIDTH-1:0]          readdataw,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rdw,
    input  logic [DATA_WIDTH-1:0]          pcplus4w,
    input  logic [DATA_WIDTH-1:0]          immextw,
    input  logic [ADDRESS_WIDTH-1:0]       pctargetw,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1d,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2d,
    output logic [DATA_WIDTH-1:0]          rd1d,
    output logic [DATA_WIDTH-1:0]          rd2d,
    output logic [DATA_WIDTH-1:0]          resultw,
    output logic [DATA_WIDTH-1:0]          a0,
    output logic [31:0]                    retirecount
);

    localparam int unsigned DEPTH = 2 ** REG_FILE_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [31:0]           retirecount_q;
    logic [31:0]           retirecount_d;
    logic [DATA_WIDTH-1:0] pctarget_ext;
    logic                  wr_en;

    // AUIPC target resized to the datapath width.
    if (ADDRESS_WIDTH >= DATA_WIDTH) begin : g_pct_trunc
        assign pctarget_ext = pctargetw[DATA_WIDTH-1:0];
    end else begin : g_pct_zext
        assign pctarget_ext = {{(DATA_WIDTH - ADDRESS_WIDTH){1'b0}}, pctargetw};
    end

    // x0 writes are discarded, so they neither update state nor bypass.
    assign wr_en = regwritew && (rdw != '0);

    // Result select; unused encodings produce zero.
    always_comb begin
        resultw = '0;
        case (resultsrcw)
            3'b000:  resultw = aluresultw;
            3'b001:  resultw = readdataw;
            3'b010:  resultw = pcplus4w;
            3'b011:  resultw = immextw;
            3'b100:  resultw = pctarget_ext;
            default: resultw = '0;
        endcase
    end

    // Next register-file state and retire count.
    always_comb begin
        regs_d        = regs_q;
        retirecount_d = retirecount_q;
        if (wr_en) begin
            regs_d[rdw]   = resultw;
            retirecount_d = retirecount_q + 32'd1;
        end
    end

    // State update; reset clears everything and masks any concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            retirecount_q <= '0;
        end else begin
            regs_q        <= regs_d;
            retirecount_q <= retirecount_d;
        end
    end

    // Read ports with write-through bypass; x0 is never written so it reads zero.
    always_comb begin
        rd1d = regs_q[rs1d];
        rd2d = regs_q[rs2d];
        if (wr_en && (rs1d == rdw)) begin
            rd1d = resultw;
        end
        if (wr_en && (rs2d == rdw)) begin
            rd2d = resultw;
        end
    end

    assign a0          = regs_q[REG_FILE_ADDR_WIDTH'(10)];
    assign retirecount = retirecount_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with an expected-value queue.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwritew;
    logic [2:0]  resultsrcw;
    logic [31:0] aluresultw;
    logic [31:0] readdataw;
    logic [4:0]  rdw;
    logic [31:0] pcplus4w;
    logic [31:0] immextw;
    logic [31:0] pctargetw;
    logic [4:0]  rs1d;
    logic [4:0]  rs2d;
    logic [31:0] rd1d;
    logic [31:0] rd2d;
    logic [31:0] resultw;
    logic [31:0] a0;
    logic [31:0] retirecount;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] sweep_exp [8];

    writeback_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .regwritew  (regwritew),
        .resultsrcw (resultsrcw),
        .aluresultw (aluresultw),
        .readdataw  (readdataw),
        .rdw        (rdw),
        .pcplus4w   (pcplus4w),
        .immextw    (immextw),
        .pctargetw  (pctargetw),
        .rs1d       (rs1d),
        .rs2d       (rs2d),
        .rd1d       (rd1d),
        .rd2d       (rd2d),
        .resultw    (resultw),
        .a0         (a0),
        .retirecount(retirecount)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] exp);
        exp_q.push_back(exp);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Advance to the next falling edge, where inputs change.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        regwritew  = 1'b0;
        resultsrcw = 3'b000;
        aluresultw = '0;
        readdataw  = '0;
        rdw        = '0;
        pcplus4w   = '0;
        immextw    = '0;
        pctargetw  = '0;
        rs1d       = '0;
        rs2d       = '0;
        @(negedge clk);
        step();
        rst = 1'b0;
        rs1d = 5'd5;
        #1;
        push(32'h0); chk("reset_retire", retirecount);
        push(32'h0); chk("reset_a0", a0);
        push(32'h0); chk("reset_rd1_x5", rd1d);

        // Write x5 from the ALU path.
        @(negedge clk);
        regwritew = 1'b1; rdw = 5'd5; resultsrcw = 3'b000; aluresultw = 32'h1234;
        rs1d = 5'd0; rs2d = 5'd0;
        push(32'h1234);
        #1 chk("alu_resultw", resultw);
        step();
        regwritew = 1'b0; rs1d = 5'd5;
        push(32'h1234);
        push(32'd1);
        #1 chk("x5_readback", rd1d);
        chk("retire_after_x5", retirecount);

        // x0 write is discarded and never bypassed.
        @(negedge clk);
        regwritew = 1'b1; rdw = 5'd0; aluresultw = 32'hFFFF; rs1d = 5'd0;
        push(32'h0);
        #1 chk("x0_same_cycle", rd1d);
        step();
        regwritew = 1'b0;
        push(32'h0);
        push(32'd1);
        #1 chk("x0_next_cycle", rd1d);
        chk("retire_x0_unchanged", retirecount);

        // Same-cycle bypass on both ports from the load path.
        @(negedge clk);
        regwritew = 1'b1; rdw = 5'd7; resultsrcw = 3'b001; readdataw = 32'hCAFE;
        rs1d = 5'd7; rs2d = 5'd7;
        push(32'hCAFE);
        push(32'hCAFE);
        #1 chk("bypass_rd1", rd1d);
        chk("bypass_rd2", rd2d);
        step();

        // Matching rdw without regwritew must not bypass.
        regwritew = 1'b0; readdataw = 32'hBEEF;
        push(32'hCAFE);
        push(32'hBEEF);
        push(32'd2);
        #1 chk("no_bypass_when_disabled", rd1d);
        chk("resultw_no_write", resultw);
        chk("retire_after_x7", retirecount);

        // Result-select sweep.
        @(negedge clk);
        aluresultw = 32'h1111_1111; readdataw = 32'h2222_2222; pcplus4w = 32'h3333_3333;
        immextw = 32'h4444_4444; pctargetw = 32'h80;
        sweep_exp = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                      32'h80, 32'h0, 32'h0, 32'h0};
        for (int s = 0; s < 8; s++) begin
            resultsrcw = 3'(s);
            push(sweep_exp[s]);
            #1 chk($sformatf("resultsrc_%0d", s), resultw);
        end

        // Independent ports: rd1 bypasses x3, rd2 reads stored x5.
        @(negedge clk);
        regwritew = 1'b1; rdw = 5'd3; resultsrcw = 3'b011; immextw = 32'hA5A5_0000;
        rs1d = 5'd3; rs2d = 5'd5;
        push(32'hA5A5_0000);
        push(32'h1234);
        #1 chk("split_rd1_bypass", rd1d);
        chk("split_rd2_stored", rd2d);
        step();

        // Write x10 then reset with a concurrent write.
        rdw = 5'd10; resultsrcw = 3'b000; aluresultw = 32'h2A;
        step();
        regwritew = 1'b0;
        push(32'h2A);
        push(32'd4);
        #1 chk("a0_written", a0);
        chk("retire_before_rst", retirecount);
        @(negedge clk);
        rst = 1'b1; regwritew = 1'b1; rdw = 5'd10; aluresultw = 32'h55; rs1d = 5'd10;
        push(32'h55);
        #1 chk("bypass_during_rst", rd1d);
        step();
        rst = 1'b0; regwritew = 1'b0; rs2d = 5'd7;
        push(32'h0);
        push(32'h0);
        push(32'h0);
        push(32'h0);
        #1 chk("a0_after_rst", a0);
        chk("retire_after_rst", retirecount);
        chk("x10_after_rst", rd1d);
        chk("x7_after_rst", rd2d);

        // Retire counter wrap from a forced preload.
        @(negedge clk);
        force dut.retirecount_q = 32'hFFFF_FFFF;
        #1 release dut.retirecount_q;
        push(32'hFFFF_FFFF);
        #1 chk("retire_preload", retirecount);
        @(negedge clk);
        regwritew = 1'b1; rdw = 5'd3; aluresultw = 32'h1; rs1d = 5'd0; rs2d = 5'd0;
        step();
        regwritew = 1'b0; rs2d = 5'd3;
        push(32'h0);
        push(32'h1);
        #1 chk("retire_wrap", retirecount);
        chk("x3_after_wrap_write", rd2d);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
